// File: rtl/id_stage_pipe_pkg.sv
// Shared opcode/funct constants, control-word layout and decode helpers for the ID stage.
package id_stage_pipe_pkg;

    localparam int EX_W         = 4;
    localparam int M_W          = 4;
    localparam int WB_W         = 2;
    localparam int MEMWRITE_BIT = 0;
    localparam int MEMREAD_BIT  = 1;
    localparam int BRANCH_BIT   = 2;
    localparam int MEMTOREG_BIT = 0;
    localparam int REGWRITE_BIT = 1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ex control = {alu_op, alu_src, reg_dst}
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_LOGI  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic [EX_W-1:0] ex;
        logic [M_W-1:0]  m;
        logic [WB_W-1:0] wb;
    } ctrl_t;

    function automatic logic reads_rt(input logic [5:0] opcode);
        return opcode inside {OP_RTYPE, OP_SW, OP_BEQ};
    endfunction

    function automatic logic is_logic_imm(input logic [5:0] opcode);
        return opcode inside {OP_ANDI, OP_ORI, OP_XORI};
    endfunction

    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT}) begin
                    c.ex               = {ALU_FUNCT, 1'b0, 1'b1};
                    c.wb[REGWRITE_BIT] = 1'b1;
                end
            end
            OP_LW: begin
                c.ex               = {ALU_ADD, 1'b1, 1'b0};
                c.m[MEMREAD_BIT]   = 1'b1;
                c.wb[REGWRITE_BIT] = 1'b1;
                c.wb[MEMTOREG_BIT] = 1'b1;
            end
            OP_SW: begin
                c.ex              = {ALU_ADD, 1'b1, 1'b0};
                c.m[MEMWRITE_BIT] = 1'b1;
            end
            OP_BEQ: begin
                c.ex            = {ALU_SUB, 1'b0, 1'b0};
                c.m[BRANCH_BIT] = 1'b1;
            end
            OP_ADDI: begin
                c.ex               = {ALU_ADD, 1'b1, 1'b0};
                c.wb[REGWRITE_BIT] = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                c.ex               = {ALU_LOGI, 1'b1, 1'b0};
                c.wb[REGWRITE_BIT] = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// IF/ID handshake, write-back port and ID/EX register outputs of the decode stage.
interface id_stage_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
);
    logic               if_valid;
    logic [31:0]        if_instr;
    logic [DATA_W-1:0]  if_pc;
    logic               id_ready;
    logic               flush;
    logic               ex_ready;
    logic               wb_we;
    logic [RADDR_W-1:0] wb_rw;
    logic [DATA_W-1:0]  wb_busw;
    logic               idex_valid;
    logic [3:0]         idex_ex_ctrl;
    logic [3:0]         idex_m_ctrl;
    logic [1:0]         idex_wb_ctrl;
    logic [DATA_W-1:0]  idex_busa;
    logic [DATA_W-1:0]  idex_busb;
    logic [DATA_W-1:0]  idex_imm;
    logic [RADDR_W-1:0] idex_rs;
    logic [RADDR_W-1:0] idex_rt;
    logic [RADDR_W-1:0] idex_rd;
    logic [DATA_W-1:0]  idex_pc;

    modport master (
        output if_valid, if_instr, if_pc, flush, ex_ready, wb_we, wb_rw, wb_busw,
        input  id_ready, idex_valid, idex_ex_ctrl, idex_m_ctrl, idex_wb_ctrl,
               idex_busa, idex_busb, idex_imm, idex_rs, idex_rt, idex_rd, idex_pc
    );

    modport slave (
        input  if_valid, if_instr, if_pc, flush, ex_ready, wb_we, wb_rw, wb_busw,
        output id_ready, idex_valid, idex_ex_ctrl, idex_m_ctrl, idex_wb_ctrl,
               idex_busa, idex_busb, idex_imm, idex_rs, idex_rt, idex_rd, idex_pc
    );
endinterface

// File: rtl/id_stage_pipe_reg_file_bypass.sv
// Register file with two async read ports, one sync write port and same-cycle write bypass.
module id_stage_pipe_reg_file_bypass #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [RADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [RADDR_W-1:0] raddr_a,
    input  logic [RADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0]  rdata_a,
    output logic [DATA_W-1:0]  rdata_b
);
    localparam int DEPTH = 2 ** RADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    // r0 is hard-wired; a write in flight to the read address wins over the array
    always_comb begin
        rdata_a = regs[raddr_a];
        if (raddr_a == '0)                  rdata_a = '0;
        else if (we && waddr == raddr_a)    rdata_a = wdata;
        rdata_b = regs[raddr_b];
        if (raddr_b == '0)                  rdata_b = '0;
        else if (we && waddr == raddr_b)    rdata_b = wdata;
    end
endmodule

// File: rtl/id_stage_pipe.sv
// DLX instruction-decode stage: control decode, operand read, immediate extend,
// load-use hazard stall and the ID/EX pipeline register.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int RADDR_W    = 5,
    parameter int ZEXT_LOGIC = 1
) (
    input logic            clk,
    input logic            rst_n,
    id_stage_pipe_if.slave bus
);
    if (DATA_W < 16) begin : g_width_check
        $error("id_stage_pipe: DATA_W must be at least 16");
    end

    typedef struct packed {
        logic               valid;
        ctrl_t              ctrl;
        logic [DATA_W-1:0]  busa;
        logic [DATA_W-1:0]  busb;
        logic [DATA_W-1:0]  imm;
        logic [RADDR_W-1:0] rs;
        logic [RADDR_W-1:0] rt;
        logic [RADDR_W-1:0] rd;
        logic [DATA_W-1:0]  pc;
    } idex_t;

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [15:0]        imm16;
    logic [RADDR_W-1:0] rs, rt, rd;
    logic [DATA_W-1:0]  busa, busb, imm_ext;
    ctrl_t              ctrl;
    logic               advance, hz, stall, load_valid;
    idex_t              idex_q, idex_d;

    assign opcode = bus.if_instr[31:26];
    assign funct  = bus.if_instr[5:0];
    assign imm16  = bus.if_instr[15:0];
    assign rs     = RADDR_W'(bus.if_instr[25:21]);
    assign rt     = RADDR_W'(bus.if_instr[20:16]);
    assign rd     = RADDR_W'(bus.if_instr[15:11]);
    assign ctrl   = decode_ctrl(opcode, funct);

    id_stage_pipe_reg_file_bypass #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (bus.wb_we),
        .waddr   (bus.wb_rw),
        .wdata   (bus.wb_busw),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (busa),
        .rdata_b (busb)
    );

    always_comb begin
        if (ZEXT_LOGIC != 0 && is_logic_imm(opcode)) imm_ext = DATA_W'(imm16);
        else                                          imm_ext = DATA_W'($signed(imm16));
    end

    // Stall only when a real instruction depends on the load; a flush kills it instead
    assign advance    = bus.ex_ready | ~idex_q.valid;
    assign hz         = idex_q.valid & idex_q.ctrl.m[MEMREAD_BIT] & (idex_q.rt != '0) &
                        ((idex_q.rt == rs) | (reads_rt(opcode) & (idex_q.rt == rt)));
    assign stall      = bus.if_valid & hz & ~bus.flush;
    assign load_valid = bus.if_valid & ~bus.flush & ~stall;
    assign bus.id_ready = ~rst_n | bus.flush | (advance & ~stall);

    always_comb begin
        idex_d = '0;
        if (load_valid) begin
            idex_d.valid = 1'b1;
            idex_d.ctrl  = ctrl;
            idex_d.busa  = busa;
            idex_d.busb  = busb;
            idex_d.imm   = imm_ext;
            idex_d.rs    = rs;
            idex_d.rt    = rt;
            idex_d.rd    = rd;
            idex_d.pc    = bus.if_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       idex_q <= '0;
        else if (advance) idex_q <= idex_d;
    end

    assign bus.idex_valid   = idex_q.valid;
    assign bus.idex_ex_ctrl = idex_q.ctrl.ex;
    assign bus.idex_m_ctrl  = idex_q.ctrl.m;
    assign bus.idex_wb_ctrl = idex_q.ctrl.wb;
    assign bus.idex_busa    = idex_q.busa;
    assign bus.idex_busb    = idex_q.busb;
    assign bus.idex_imm     = idex_q.imm;
    assign bus.idex_rs      = idex_q.rs;
    assign bus.idex_rt      = idex_q.rt;
    assign bus.idex_rd      = idex_q.rd;
    assign bus.idex_pc      = idex_q.pc;
endmodule
